// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory behind a req/addr_ok/data_ok handshake.
// Ports: clk, rst (async, active-low); req/wr/addr/sel/wdata in; addr_ok/data_ok/rdata out.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                mem_we;

  logic [31:0] mem [2**ADDR_W];

  // Byte offset and bits above the array size alias silently.
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        addr_ok = req & rst;
        if (req) begin
          idx_d   = addr[ADDR_W+1:2];
          wr_d    = wr;
          sel_d   = sel;
          wdata_d = wdata;
          if (LAT == 4'd0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        data_ok = 1'b1;
        mem_we  = wr_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  // Commit happens on the edge leaving RESP; reset forces IDLE
  // asynchronously, so an aborted store never reaches this write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign rdata = (data_ok && !wr_q) ? mem[idx_q] : 32'd0;

endmodule
